// File: rtl/score_keeper_if.sv
// score_keeper_if: game-event inputs and score outputs between the game logic and the score keeper.
interface score_keeper_if;
    logic        tick;
    logic        catch_evt;
    logic [3:0]  catch_pts;
    logic        miss_evt;
    logic        game_restart;
    logic        game_over;
    logic [13:0] score;
    logic [13:0] high_score;
    logic        new_score;
    logic [2:0]  multiplier;
    logic        new_high;
    modport master (
        output tick, catch_evt, catch_pts, miss_evt, game_restart, game_over,
        input  score, high_score, new_score, multiplier, new_high
    );
    modport slave (
        input  tick, catch_evt, catch_pts, miss_evt, game_restart, game_over,
        output score, high_score, new_score, multiplier, new_high
    );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: saturating score with streak-based combo multiplier, frame-timed streak expiry and session high score.
module score_keeper #(
    parameter int MAX_SCORE    = 9999,
    parameter int COMBO_FRAMES = 90,
    parameter int STREAK_STEP  = 4
) (
    input logic clk,
    input logic reset,
    score_keeper_if.slave sk
);
    localparam int TW = $clog2(COMBO_FRAMES + 1);
    logic [13:0]   r_score, r_high;
    logic          r_new_score, r_new_high;
    logic [2:0]    r_mult;
    logic [3:0]    r_streak;
    logic [TW-1:0] r_timer;
    logic          w_live, w_catch, w_miss, w_tick, w_raise;
    logic [14:0]   w_sum;
    logic [13:0]   w_score;
    logic [3:0]    w_streak, w_step;
    logic [TW-1:0] w_timer;
    logic [2:0]    w_mult;
    always_comb begin
        w_live   = ~sk.game_over & ~sk.game_restart;
        w_catch  = sk.catch_evt & w_live;
        w_miss   = sk.miss_evt & w_live;
        w_tick   = sk.tick & w_live & ~w_catch & (r_timer != '0);
        w_raise  = r_score > r_high;
        w_sum    = 15'(r_score) + 15'(sk.catch_pts) * 15'(r_mult);
        w_score  = sk.game_restart ? 14'd0
                 : w_catch ? (w_sum > 15'(MAX_SCORE) ? 14'(MAX_SCORE) : w_sum[13:0])
                 : r_score;
        // miss beats a simultaneous catch for the streak; an expiring tick only clears without a catch
        w_streak = (sk.game_restart | w_miss) ? 4'd0
                 : w_catch ? (r_streak == 4'd15 ? 4'd15 : r_streak + 4'd1)
                 : (w_tick && r_timer == TW'(1)) ? 4'd0
                 : r_streak;
        w_timer  = sk.game_restart ? '0
                 : w_catch ? TW'(COMBO_FRAMES)
                 : w_tick ? r_timer - TW'(1)
                 : r_timer;
        w_step   = w_streak / 4'(STREAK_STEP);
        w_mult   = w_step >= 4'd3 ? 3'd4 : 3'(w_step) + 3'd1;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_score     <= '0;
            r_high      <= '0;
            r_new_score <= 1'b0;
            r_new_high  <= 1'b0;
            r_mult      <= 3'd1;
            r_streak    <= '0;
            r_timer     <= '0;
        end else begin
            r_score     <= w_score;
            r_new_score <= w_score != r_score;
            r_streak    <= w_streak;
            r_timer     <= w_timer;
            r_mult      <= w_mult;
            if (w_raise) r_high <= r_score;
            r_new_high  <= ~sk.game_restart & (r_new_high | w_raise);
        end
    end
    assign sk.score      = r_score;
    assign sk.high_score = r_high;
    assign sk.new_score  = r_new_score;
    assign sk.multiplier = r_mult;
    assign sk.new_high   = r_new_high;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: table vectors, corner sequences and random traffic checked against an integer score model.
module tb_score_keeper;
    localparam int MAXS = 9999;
    localparam int CF   = 90;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    int ms = 0, mh = 0, mst = 0, mtm = 0, mpl = 0, mnh = 0;
    score_keeper_if sk();
    score_keeper dut (.clk(clk), .reset(reset), .sk(sk.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic c; logic [3:0] p; logic m, t, rs, go, rn;
        int s, h, mu, pl, nh;
    } vec_t;
    vec_t tbl[17];
    function automatic int mmul(input int st);
        return 1 + ((st / 4) > 3 ? 3 : st / 4);
    endfunction
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask
    task automatic step(input logic c, input logic [3:0] p, input logic m, t, rs, go, rn);
        int r;
        bit raise;
        sk.catch_evt = c; sk.catch_pts = p; sk.miss_evt = m; sk.tick = t;
        sk.game_restart = rs; sk.game_over = go; reset = rn;
        if (!rn) begin
            ms = 0; mh = 0; mst = 0; mtm = 0; mpl = 0; mnh = 0;
        end else begin
            raise = ms > mh;
            if (raise) mh = ms;
            mpl = 0;
            if (rs) begin
                mpl = ms != 0; ms = 0; mst = 0; mtm = 0; mnh = 0;
            end else begin
                mnh = mnh | raise;
                if (!go) begin
                    if (c) begin
                        r = ms + p * mmul(mst);
                        if (r > MAXS) r = MAXS;
                        mpl = r != ms;
                        ms = r;
                        mst = m ? 0 : (mst < 15 ? mst + 1 : 15);
                        mtm = CF;
                    end else begin
                        if (m) mst = 0;
                        if (t && mtm > 0) begin
                            mtm--;
                            if (mtm == 0) mst = 0;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("model_score", sk.score, ms);
        chk("model_high", sk.high_score, mh);
        chk("model_pulse", sk.new_score, mpl);
        chk("model_mult", sk.multiplier, mmul(mst));
        chk("model_new_high", sk.new_high, mnh);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
    endtask
    task automatic catch1(input logic [3:0] p);
        step(1, p, 0, 0, 0, 0, 1);
    endtask
    initial begin
        logic go_lvl;
        int cp;
        sk.catch_evt = 0; sk.catch_pts = 0; sk.miss_evt = 0; sk.tick = 0;
        sk.game_restart = 0; sk.game_over = 0;
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0,  0,  0, 1, 0, 0};
        tbl[1]  = '{1, 5, 0, 0, 0, 0, 1,  5,  0, 1, 1, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 1,  5,  5, 1, 0, 1};
        tbl[3]  = '{1, 5, 0, 0, 0, 0, 1, 10,  5, 1, 1, 1};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 1, 10, 10, 1, 0, 1};
        tbl[5]  = '{1, 5, 0, 0, 0, 0, 1, 15, 10, 1, 1, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 1, 15, 15, 1, 0, 1};
        tbl[7]  = '{0, 0, 0, 0, 1, 0, 1,  0, 15, 1, 1, 0};
        tbl[8]  = '{1, 1, 0, 0, 0, 0, 1,  1, 15, 1, 1, 0};
        tbl[9]  = '{1, 1, 0, 0, 0, 0, 1,  2, 15, 1, 1, 0};
        tbl[10] = '{1, 1, 0, 0, 0, 0, 1,  3, 15, 1, 1, 0};
        tbl[11] = '{1, 1, 0, 0, 0, 0, 1,  4, 15, 2, 1, 0};
        tbl[12] = '{1, 1, 0, 0, 0, 0, 1,  6, 15, 2, 1, 0};
        tbl[13] = '{1, 1, 0, 0, 0, 0, 1,  8, 15, 2, 1, 0};
        tbl[14] = '{1, 1, 0, 0, 0, 0, 1, 10, 15, 2, 1, 0};
        tbl[15] = '{1, 1, 0, 0, 0, 0, 1, 12, 15, 3, 1, 0};
        tbl[16] = '{0, 0, 1, 0, 0, 0, 1, 12, 15, 1, 0, 0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].c, tbl[i].p, tbl[i].m, tbl[i].t, tbl[i].rs, tbl[i].go, tbl[i].rn);
            chk($sformatf("vec%0d_score", i), sk.score, tbl[i].s);
            chk($sformatf("vec%0d_high", i), sk.high_score, tbl[i].h);
            chk($sformatf("vec%0d_mult", i), sk.multiplier, tbl[i].mu);
            chk($sformatf("vec%0d_pulse", i), sk.new_score, tbl[i].pl);
            chk($sformatf("vec%0d_new_high", i), sk.new_high, tbl[i].nh);
        end
        // saturation: catch+miss keeps multiplier at 1 while climbing to 9995
        step(0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 666; i++) step(1, 15, 1, 0, 0, 0, 1);
        step(1, 5, 1, 0, 0, 0, 1);
        chk("sat_pre_score", sk.score, 9995);
        chk("sat_pre_mult", sk.multiplier, 1);
        catch1(10);
        chk("sat_score", sk.score, 9999);
        chk("sat_pulse", sk.new_score, 1);
        catch1(10);
        chk("sat_hold_score", sk.score, 9999);
        chk("sat_hold_pulse", sk.new_score, 0);
        // combo expiry, then a catch on the expiring tick
        step(0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) catch1(0);
        chk("combo_mult4", sk.multiplier, 2);
        for (int i = 0; i < CF - 1; i++) step(0, 0, 0, 1, 0, 0, 1);
        chk("combo_before_expire", sk.multiplier, 2);
        step(0, 0, 0, 1, 0, 0, 1);
        chk("combo_expired", sk.multiplier, 1);
        for (int i = 0; i < 4; i++) catch1(0);
        for (int i = 0; i < CF - 1; i++) step(0, 0, 0, 1, 0, 0, 1);
        step(1, 0, 0, 1, 0, 0, 1);
        chk("combo_saved", sk.multiplier, 2);
        // restart together with a catch
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) catch1(10);
        idle(1);
        chk("rst_pre_score", sk.score, 40);
        chk("rst_pre_high", sk.high_score, 40);
        step(1, 10, 0, 0, 1, 0, 1);
        chk("restart_score", sk.score, 0);
        chk("restart_pulse", sk.new_score, 1);
        chk("restart_high", sk.high_score, 40);
        chk("restart_new_high", sk.new_high, 0);
        chk("restart_mult", sk.multiplier, 1);
        idle(1);
        chk("restart_pulse_once", sk.new_score, 0);
        // game over freezes everything
        for (int i = 0; i < 4; i++) catch1(7);
        idle(2);
        step(1, 9, 0, 0, 0, 1, 1);
        chk("go_catch_score", sk.score, 28);
        chk("go_catch_pulse", sk.new_score, 0);
        step(0, 0, 1, 0, 0, 1, 1);
        chk("go_miss_mult", sk.multiplier, 2);
        step(0, 0, 0, 1, 0, 1, 1);
        chk("go_tick_score", sk.score, 28);
        chk("go_high", sk.high_score, 40);
        step(1, 5, 0, 0, 0, 0, 0);
        chk("reset_score", sk.score, 0);
        chk("reset_high", sk.high_score, 0);
        chk("reset_mult", sk.multiplier, 1);
        chk("reset_pulse", sk.new_score, 0);
        chk("reset_new_high", sk.new_high, 0);
        // random traffic with alternating dense and sparse catch phases
        go_lvl = 0;
        for (int i = 0; i < 4000; i++) begin
            cp = ((i / 500) % 2) ? 40 : 2;
            if ($urandom_range(0, 49) == 0) go_lvl = ~go_lvl;
            step($urandom_range(0, cp) == 0, 4'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 149) == 0, go_lvl,
                 $urandom_range(0, 299) != 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Upstream of the score display stage.
- Turns per-event game inputs (egg caught, egg missed, round restart) into a saturating 14-bit binary score and a session high score.
- Applies a streak-based combo multiplier with a frame-timed expiry.
- Emits a one-cycle new_score strobe. The display stage uses this strobe to start its binary-to-BCD conversion.

Parameters:
- MAX_SCORE, 9999, saturation ceiling for score and high_score; must be at most 16383.
- COMBO_FRAMES, 90, number of frame ticks without a catch after which the streak expires.
- STREAK_STEP, 4, catches per multiplier step.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- tick  in  1  one-cycle pulse per video frame.
- catch_evt  in  1  one-cycle pulse: egg caught.
- catch_pts  in  4  base points for this catch, valid with catch_evt.
- miss_evt  in  1  one-cycle pulse: egg missed.
- game_restart  in  1  one-cycle pulse: start a new round.
- game_over  in  1  level: round ended, freeze scoring.
- score  out  14  current score.
- high_score  out  14  best score since reset.
- new_score  out  1  one-cycle strobe: score changed.
- multiplier  out  3  current combo multiplier, 1..4.
- new_high  out  1  level: high_score was raised during the current round.

Behaviour:
- Reset (reset==0 at a clk edge): score=0, high_score=0, new_score=0, multiplier=1, new_high=0, streak=0, combo timer=0.
- streak: 4-bit count of consecutive catches, saturating at 15.
- multiplier = 1 + min(streak / STREAK_STEP, 3). It is registered and reflects the streak before the current catch.
- Catch (catch_evt=1, game_over=0, game_restart=0):
  - sum = score + catch_pts*multiplier, computed at 15 bits; result = min(sum, MAX_SCORE).
  - score takes result on the next edge.
  - streak increments (saturating); combo timer reloads to COMBO_FRAMES.
- new_score:
  - Registered; high for exactly the one cycle in which the changed score value is first visible on score.
  - Not asserted if the result equals the old score (catch_pts=0, or already at MAX_SCORE).
- Miss (miss_evt=1, game_over=0): streak=0, multiplier=1 on the next edge; score unchanged.
- Catch and miss in the same cycle: points use the pre-event multiplier, then streak=0 (miss wins for streak).
- Combo timer:
  - Decrements on each tick while nonzero and no catch is present.
  - Reaching 0 through a decrement clears the streak.
  - A catch in the same cycle as the expiring tick wins: timer reloads and streak increments.
- High score:
  - The cycle after score is written, if score > high_score: high_score = score, new_high=1.
  - high_score therefore lags score by one cycle.
- game_restart:
  - Overrides all other events in that cycle.
  - score=0, streak=0, timer=0, new_high=0.
  - new_score pulses if the old score was nonzero.
  - high_score is retained.
- game_over=1: catch_evt, miss_evt and tick are ignored; outputs hold. game_restart is still honoured.
- Arithmetic: catch_pts*multiplier is at most 60. There is no wrap-around at any point; saturation is the only overflow behaviour.
- Reset mid-round, including in the same cycle as events: reset wins, all state is cleared, no new_score pulse.

Test Plan:
- Reset, then 3 catches of catch_pts=5 spaced 2 cycles apart → score 5, 10, 15; exactly 3 new_score pulses, each coincident with the new value; high_score 15 one cycle after the last; new_high=1.
- 8 consecutive catches of 1 point → multiplier 1,1,1,1,2,2,2,2 applied → score 12; after the 8th catch multiplier=3. Then miss_evt → multiplier=1, score stays 12.
- Preload score to 9995 via catches, then catch_pts=10 with multiplier 1 → score=9999, one pulse. Another catch → score stays 9999, no pulse.
- Streak=4, then COMBO_FRAMES ticks with no catch → multiplier drops to 1 on the expiring tick. Repeat with a catch in the same cycle as the expiring tick → streak=5, multiplier=2.
- Score 40, high 40, then game_restart together with catch_evt → score=0, one new_score pulse, high_score=40, new_high=0, catch ignored.
- game_over=1 with catch/miss/tick pulses → no output change, no pulse. reset asserted low during a catch → all outputs 0 next cycle and multiplier=1.
